sfifo_burst_reader: RTL and testbench
=====================================

Name: sfifo_burst_reader

Overview:
- Read-side drain engine for the team's synchronous FIFO when that FIFO is configured for asynchronous read, so data is valid whenever the FIFO is not empty.
- Waits until the FIFO holds a full burst, or until a partial burst has waited past a timeout.
- Reads exactly that many words and presents them on a valid/ready sample stream, with o_last on the final beat.
- Sits between sample-rate producers and packet-oriented consumers, for example a DMA or network framer, in the SDR datapath.

Parameters:
- BW, 8, data width; must match the FIFO BW.
- LGFLEN, 4, log2 of the FIFO depth; sets the i_fifo_fill width.
- BURST, 4, words per full burst; legal range is 1 <= BURST <= 2^LGFLEN.
- TIMEOUT, 8, idle cycles with a non-empty FIFO before a partial burst is forced; 0 disables partial bursts.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_fifo_empty  in  1  FIFO empty flag
- i_fifo_fill  in  LGFLEN+1  FIFO fill count
- i_fifo_data  in  BW  FIFO head word, valid when !i_fifo_empty
- o_fifo_rd  out  1  FIFO read strobe (combinational)
- o_valid  out  1  stream beat valid
- i_ready  in  1  downstream accepts the beat
- o_data  out  BW  stream beat data
- o_last  out  1  final beat of the burst
- o_busy  out  1  high while state is BURST

Behaviour:
- Reset is synchronous, active-high, on i_reset; clock is i_clk.
- Reset values:
  - state = IDLE
  - o_valid = 0, o_last = 0, o_data = 0
  - remaining count rem = 0, timeout timer = 0
  - o_fifo_rd = 0 during any cycle in which i_reset is high.
- States: IDLE and BURST, two-state one-hot or binary; encoding is in the package.
- IDLE:
  - o_fifo_rd = 0.
  - If i_fifo_fill >= BURST: rem <= BURST, go to BURST, timer <= 0.
  - Else if TIMEOUT != 0, fill != 0, and timer == TIMEOUT-1: rem <= fill, go to BURST, timer <= 0.
  - Else if fill != 0: timer increments.
  - Else: timer <= 0.
  - Timer saturates and never wraps. Its width is clog2(TIMEOUT+1).
- BURST:
  - o_fifo_rd = !i_fifo_empty && rem != 0 && (!o_valid || i_ready).
  - On each read: o_data <= i_fifo_data, o_valid <= 1, o_last <= (rem == 1), rem <= rem - 1.
  - When the read with rem == 1 occurs, go to IDLE in the same edge.
- Output handshake:
  - If o_valid && i_ready and no read happens this cycle: o_valid <= 0, o_last <= 0.
  - While o_valid && !i_ready: o_data and o_last hold stable, and no read occurs.
- Latency:
  - The fill threshold is met in cycle N.
  - o_busy and o_fifo_rd are high in N+1.
  - The first o_valid appears in N+2.
- Throughput: one beat per cycle while i_ready is held high; no bubbles within a burst.
- Back-to-back bursts:
  - IDLE may re-enter BURST while the previous last beat is still pending.
  - The next first read waits on the !o_valid || i_ready gate.
  - The minimum gap between bursts is one cycle with no read, the IDLE cycle.
- Width rule: rem is LGFLEN+1 bits; the fill compare is unsigned.
- Boundary conditions:
  - The FIFO cannot starve mid-burst, because the burst length is never larger than the fill at start and this block is the only reader.
  - If the FIFO does go empty, the engine stalls with rem held and never skips a word.
  - A full FIFO (fill = 2^LGFLEN) is handled identically to fill >= BURST.
  - Reset mid-burst drops the pending beat and rem. It does not flush the FIFO; remaining words start a fresh burst.

Decomposition:
- Package sfifo_pkg holds:
  - the state encoding constants (IDLE, BURST)
  - a function computing timer width from TIMEOUT
  - an elaboration check that BURST <= 2^LGFLEN.
- No sub-module is needed; the output register is inline.
- The test bench instantiates the existing sfifo with OPT_ASYNC_READ = 1 feeding this block.

Test Plan:
- Full burst: write 0x10,0x11,0x12,0x13 with i_ready = 1.
  - Beats arrive 0x10..0x13 on consecutive cycles, o_last only on 0x13.
  - First o_valid 2 cycles after the fill reaches 4.
- Partial burst: write 0xA0,0xA1, then stop.
  - After 8 idle cycles, a 2-beat burst 0xA0,0xA1 with o_last on 0xA1.
  - With TIMEOUT = 0, nothing is emitted.
- Backpressure: 4 words buffered, i_ready low for 5 cycles after the first o_valid.
  - o_data = first word holds, and o_fifo_rd stays 0.
  - After release, the remaining 3 beats follow in order.
- Back-to-back: write 12 words continuously with i_ready = 1.
  - Three 4-beat bursts, o_last on beats 4, 8 and 12, data in order with no loss.
- Reset mid-burst: assert i_reset after beat 2 of 4.
  - Next cycle: o_valid = 0, o_busy = 0.
  - The remaining 2 words later emerge as a timeout partial burst.
- Random: random writes and random i_ready over 10k cycles.
  - Scoreboard order matches writes, every burst is <= BURST beats, and o_last closes each burst.

Source files
------------

// File: rtl/sfifo_pkg.sv
// Shared definitions for the sfifo read-side burst engine: state encoding,
// timer sizing and the burst-length legality check.
package sfifo_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  // Width needed to count 0..timeout; never narrower than one bit.
  function automatic int timer_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic bit burst_fits(input int burst, input int lgflen);
    return (burst >= 1) && (burst <= (1 << lgflen));
  endfunction

endpackage

// File: rtl/sfifo_burst_reader.sv
// Drains an async-read sfifo in bursts of BURST words (or a timed-out partial
// burst) onto a valid/ready stream, flagging the final beat with o_last.
module sfifo_burst_reader
  import sfifo_pkg::*;
#(
  parameter int BW      = 8,
  parameter int LGFLEN  = 4,
  parameter int BURST   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_fifo_empty,
  input  logic [LGFLEN:0]   i_fifo_fill,
  input  logic [BW-1:0]     i_fifo_data,
  output logic              o_fifo_rd,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [BW-1:0]     o_data,
  output logic              o_last,
  output logic              o_busy
);

  // Stream handshake: a beat transfers on any rising edge where o_valid and
  // i_ready are both high; while o_valid && !i_ready, o_data/o_last hold.

  localparam int              TW        = timer_width(TIMEOUT);
  localparam logic [LGFLEN:0] BURST_LEN = (LGFLEN+1)'(BURST);
  localparam logic [LGFLEN:0] REM_ONE   = (LGFLEN+1)'(1);
  localparam logic [TW-1:0]   TMO_LAST  = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);
  localparam logic [TW-1:0]   TMR_MAX   = '1;

  generate
    if (!burst_fits(BURST, LGFLEN)) begin : g_bad_burst
      $error("sfifo_burst_reader: BURST must be in 1..2**LGFLEN");
    end
  endgenerate

  state_t          state, state_n;
  logic [LGFLEN:0] rem, rem_n;
  logic [TW-1:0]   timer, timer_n;
  logic            valid_n, last_n;
  logic [BW-1:0]   data_n;
  logic            rd;

  always_comb begin
    state_n = state;
    rem_n   = rem;
    timer_n = timer;
    rd      = 1'b0;
    valid_n = o_valid;
    last_n  = o_last;
    data_n  = o_data;

    case (state)
      ST_IDLE: begin
        if (i_fifo_fill >= BURST_LEN) begin
          rem_n   = BURST_LEN;
          state_n = ST_BURST;
          timer_n = '0;
        end else if ((TIMEOUT != 0) && (i_fifo_fill != '0) && (timer == TMO_LAST)) begin
          rem_n   = i_fifo_fill;
          state_n = ST_BURST;
          timer_n = '0;
        end else if (i_fifo_fill != '0) begin
          if (timer != TMR_MAX) timer_n = timer + 1'b1;
        end else begin
          timer_n = '0;
        end
      end
      ST_BURST: begin
        // An empty FIFO simply stalls the burst; rem is kept so no word is skipped.
        rd = !i_fifo_empty && (rem != '0) && (!o_valid || i_ready) && !i_reset;
        if (rd) begin
          rem_n = rem - REM_ONE;
          if (rem == REM_ONE) state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (rd) begin
      data_n  = i_fifo_data;
      valid_n = 1'b1;
      last_n  = (rem == REM_ONE);
    end else if (o_valid && i_ready) begin
      valid_n = 1'b0;
      last_n  = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= ST_IDLE;
      rem     <= '0;
      timer   <= '0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      o_data  <= '0;
    end else begin
      state   <= state_n;
      rem     <= rem_n;
      timer   <= timer_n;
      o_valid <= valid_n;
      o_last  <= last_n;
      o_data  <= data_n;
    end
  end

  assign o_fifo_rd = rd;
  assign o_busy    = (state == ST_BURST);

endmodule

// File: tb/tb_sfifo_burst_reader.sv
// Bench for sfifo_burst_reader: a small async-read FIFO feeds the engine;
// expected beats are queued at write time and checked by a stream monitor.
module tb_sfifo_burst_reader;

  localparam int              BW      = 8;
  localparam int              LGFLEN  = 4;
  localparam int              BURST   = 4;
  localparam int              TIMEOUT = 8;
  localparam logic [LGFLEN:0] DEPTH   = 5'd16;

  logic              clk = 1'b0;
  logic              rst, rst0, fclr;
  logic              wr;
  logic [BW-1:0]     wdata;
  logic              empty;
  logic [LGFLEN:0]   fill;
  logic [BW-1:0]     fdata;
  logic              rd, valid, ready, last, busy;
  logic [BW-1:0]     data;
  logic              rd0, valid0, last0, busy0;
  logic [BW-1:0]     data0;

  int total = 0;
  int bad   = 0;

  // Expected beat: {check_last, last, data}
  logic [BW+1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired act=running exp=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- FIFO model (async read) ----------------
  logic [BW-1:0]     mem [16];
  logic [LGFLEN-1:0] wp, rp;
  logic [LGFLEN:0]   cnt;
  logic              wa;

  assign wa    = wr && (cnt < DEPTH);
  assign fill  = cnt;
  assign empty = (cnt == '0);
  assign fdata = mem[rp];

  always @(posedge clk) begin
    if (fclr) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wa) begin
        mem[wp] <= wdata;
        wp      <= wp + 1'b1;
      end
      if (rd) rp <= rp + 1'b1;
      cnt <= cnt + {4'b0, wa} - {4'b0, rd};
    end
  end

  // ---------------- DUTs ----------------
  sfifo_burst_reader #(.BW(BW), .LGFLEN(LGFLEN), .BURST(BURST), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_reset(rst), .i_fifo_empty(empty), .i_fifo_fill(fill),
    .i_fifo_data(fdata), .o_fifo_rd(rd), .o_valid(valid), .i_ready(ready),
    .o_data(data), .o_last(last), .o_busy(busy)
  );

  // Observes the same FIFO but never pops it; only its silence is checked.
  sfifo_burst_reader #(.BW(BW), .LGFLEN(LGFLEN), .BURST(BURST), .TIMEOUT(0)) dut0 (
    .i_clk(clk), .i_reset(rst0), .i_fifo_empty(empty), .i_fifo_fill(fill),
    .i_fifo_data(fdata), .o_fifo_rd(rd0), .o_valid(valid0), .i_ready(1'b1),
    .o_data(data0), .o_last(last0), .o_busy(busy0)
  );

  // ---------------- helpers / driver tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_word(input logic [BW-1:0] d, input bit push, input bit lst);
    wr    = 1'b1;
    wdata = d;
    if (push && (cnt < DEPTH)) exp_q.push_back({1'b1, lst, d});
    step();
    wr = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while ((exp_q.size() != 0 || valid || busy || cnt != '0) && n < budget) begin
      step();
      n++;
    end
    chk(name, 32'(n < budget), 32'd1);
    repeat (2) step();
  endtask

  // ---------------- scoreboard monitor ----------------
  int            bcount = 0;
  logic [BW+1:0] e;

  always @(negedge clk) begin
    if (rst) begin
      bcount = 0;
    end else if (valid && ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL beat_unexpected act=%0h exp=none", data);
      end else begin
        e = exp_q.pop_front();
        chk("beat_data", 32'(data), 32'(e[BW-1:0]));
        if (e[BW+1]) chk("beat_last", 32'(last), 32'(e[BW]));
      end
      bcount++;
      if (last) begin
        chk("burst_len_max", 32'(bcount <= BURST), 32'd1);
        bcount = 0;
      end else begin
        chk("burst_open_max", 32'(bcount < BURST), 32'd1);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int  k;
    bit  found, any0;
    logic busy_n1, rd_n1;

    ready = 1'b1; wr = 1'b0; wdata = '0;
    rst = 1'b1; rst0 = 1'b1; fclr = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_last",  32'(last),  32'd0);
    chk("reset_data",  32'(data),  32'd0);
    chk("reset_busy",  32'(busy),  32'd0);
    chk("reset_rd",    32'(rd),    32'd0);
    step();
    rst = 1'b0; rst0 = 1'b0; fclr = 1'b0;
    repeat (2) step();

    // Full burst and its latency from fill reaching BURST
    for (int i = 0; i < 4; i++) wr_word(8'h10 + 8'(i), 1'b1, i == 3);
    k = 0; busy_n1 = 1'b0; rd_n1 = 1'b0;
    while (k < 10) begin
      @(negedge clk);
      if (valid) break;
      if (k == 1) begin busy_n1 = busy; rd_n1 = rd; end
      k++;
    end
    chk("full_first_valid_lat", 32'(k), 32'd2);
    chk("full_busy_n1", 32'(busy_n1), 32'd1);
    chk("full_rd_n1",   32'(rd_n1),   32'd1);
    wait_idle(50, "full_drain");

    // Partial burst after timeout; TIMEOUT=0 instance stays silent
    rst0 = 1'b1; step(); rst0 = 1'b0;
    wr_word(8'hA0, 1'b1, 1'b0);
    wr_word(8'hA1, 1'b1, 1'b1);
    k = 0; any0 = 1'b0;
    while (k < 30) begin
      @(negedge clk);
      any0 = any0 | busy0 | valid0 | rd0;
      if (valid) break;
      k++;
    end
    chk("partial_wait_cycles", 32'(k), 32'd8);
    chk("tmo0_silent", 32'(any0), 32'd0);
    wait_idle(50, "partial_drain");

    // Backpressure: first beat holds, no reads while stalled
    ready = 1'b0;
    for (int i = 0; i < 4; i++) wr_word(8'h30 + 8'(i), 1'b1, i == 3);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = valid;
    end
    chk("bp_first_valid_seen", 32'(found), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_data_hold", 32'(data), 32'h30);
      chk("bp_rd_low", 32'(rd), 32'd0);
      if (i < 4) @(negedge clk);
    end
    step();
    ready = 1'b1;
    wait_idle(50, "bp_drain");

    // Back-to-back: 12 continuous words form three 4-beat bursts
    for (int i = 0; i < 12; i++) wr_word(8'h40 + 8'(i), 1'b1, (i % 4) == 3);
    wait_idle(80, "b2b_drain");

    // Full FIFO (16 words waiting behind a stalled beat)
    ready = 1'b0;
    for (int i = 0; i < 17; i++)
      wr_word(8'h60 + 8'(i), 1'b1, (i % 4) == 3 || i == 16);
    @(negedge clk);
    chk("fullfifo_stall_rd", 32'(rd), 32'd0);
    step();
    ready = 1'b1;
    wait_idle(120, "fullfifo_drain");

    // Reset while beat 2 is presented: it is dropped, B2/B3 come out later
    wr_word(8'hB0, 1'b1, 1'b0);
    wr_word(8'hB1, 1'b0, 1'b0);
    wr_word(8'hB2, 1'b1, 1'b0);
    wr_word(8'hB3, 1'b1, 1'b1);
    k = 0;
    while (!(valid && data == 8'hB1) && k < 20) begin
      step();
      k++;
    end
    chk("rst_beat2_seen", 32'(k < 20), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_rd_low", 32'(rd), 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid_cleared", 32'(valid), 32'd0);
    chk("rst_busy_cleared",  32'(busy),  32'd0);
    wait_idle(60, "rst_drain");

    // Random writes and random backpressure
    for (int i = 0; i < 10000; i++) begin
      wr    = ($urandom_range(0, 1) == 1);
      wdata = 8'($urandom_range(0, 255));
      ready = ($urandom_range(0, 3) != 0);
      if (wr && (cnt < DEPTH)) exp_q.push_back({2'b00, wdata});
      step();
    end
    wr = 1'b0;
    ready = 1'b1;
    wait_idle(400, "random_drain");

    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
